pdm_density_counter: RTL and testbench

Sliding-window pulse-density counter for one PDM microphone channel. Counts the ones among the most recent WIN PDM samples and publishes the count as a 10-bit level with a one-cycle valid strobe. Sits directly upstream of the per-channel hysteresis threshold detector, whose `cntr`/`cntr_valid` inputs it drives (detector thresholds 800/400 assume WIN = 1000).

---
 rtl/pdm_density_counter.sv | 77 +++++++
 tb/tb_pdm_density_counter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_density_counter.sv
// Sliding-window ones counter for one PDM channel: publishes the number of ones
// among the last WIN accepted samples as a 10-bit level with a one-cycle strobe.
module pdm_density_counter #(
  parameter int unsigned WIN = 1000,
  parameter int unsigned DEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pdm_bit,
  input  logic       pdm_valid,
  output logic [9:0] cntr,
  output logic       cntr_valid,
  output logic       filled
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned DW = (DEC > 1) ? $clog2(DEC) : 1;

  logic          win_buf [WIN];
  logic [AW-1:0] wptr;
  logic [CW-1:0] sum;
  logic [CW-1:0] fcnt;
  logic [DW-1:0] dcnt;

  logic          old_c;
  logic [AW-1:0] wptr_nxt_c;
  logic [CW-1:0] sum_nxt_c;
  logic [CW-1:0] fcnt_nxt_c;
  logic [DW-1:0] dcnt_nxt_c;
  logic          full_c;

  // Next-state arithmetic for one accepted sample; stale entries only count once filled.
  always_comb begin
    old_c      = win_buf[wptr];
    wptr_nxt_c = (wptr == AW'(WIN - 1)) ? '0 : wptr + AW'(1);
    sum_nxt_c  = sum + CW'(pdm_bit) - CW'(filled & old_c);
    fcnt_nxt_c = (fcnt < CW'(WIN)) ? fcnt + CW'(1) : fcnt;
    dcnt_nxt_c = (dcnt == DW'(DEC - 1)) ? '0 : dcnt + DW'(1);
    full_c     = (fcnt_nxt_c == CW'(WIN));
  end

  // Sample history is never cleared; the fill counter masks stale contents.
  always_ff @(posedge clk) begin
    if (pdm_valid && !rst) begin
      win_buf[wptr] <= pdm_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      sum        <= '0;
      fcnt       <= '0;
      dcnt       <= '0;
      cntr       <= '0;
      cntr_valid <= 1'b0;
      filled     <= 1'b0;
    end else begin
      cntr_valid <= 1'b0;
      if (pdm_valid) begin
        wptr   <= wptr_nxt_c;
        sum    <= sum_nxt_c;
        fcnt   <= fcnt_nxt_c;
        filled <= full_c;
        if (full_c) begin
          dcnt <= dcnt_nxt_c;
          if (dcnt == '0) begin
            cntr       <= sum_nxt_c;
            cntr_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_density_counter.sv
// Three differently-parameterised counters share one stimulus stream; each is
// scored against a window-sum model of the accepted-sample history.
module tb_pdm_density_counter;

  typedef struct {
    int stamp;
    int val;
  } exp_t;

  localparam int NI = 3;
  localparam int W0 = 1000, D0 = 1;
  localparam int W1 = 1000, D1 = 4;
  localparam int W2 = 2,    D2 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pdm_bit = 1'b0;
  logic       pdm_valid = 1'b0;
  logic [9:0] cntr0, cntr1, cntr2;
  logic       cv0, cv1, cv2;
  logic       f0, f1, f2;

  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  bit   chk_en = 1'b0;
  bit   hist[$];
  exp_t q0[$], q1[$], q2[$];
  int   held[NI];
  int   wins[NI] = '{W0, W1, W2};
  int   decs[NI] = '{D0, D1, D2};
  logic pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  pdm_density_counter #(.WIN(W0), .DEC(D0)) u0 (
    .clk(clk), .rst(rst), .pdm_bit(pdm_bit), .pdm_valid(pdm_valid),
    .cntr(cntr0), .cntr_valid(cv0), .filled(f0));
  pdm_density_counter #(.WIN(W1), .DEC(D1)) u1 (
    .clk(clk), .rst(rst), .pdm_bit(pdm_bit), .pdm_valid(pdm_valid),
    .cntr(cntr1), .cntr_valid(cv1), .filled(f1));
  pdm_density_counter #(.WIN(W2), .DEC(D2)) u2 (
    .clk(clk), .rst(rst), .pdm_bit(pdm_bit), .pdm_valid(pdm_valid),
    .cntr(cntr2), .cntr_valid(cv2), .filled(f2));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int qsize(int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qpush(int k, exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Ones among the last w accepted samples since reset.
  function automatic int win_sum(int w);
    int s = 0;
    for (int i = hist.size() - w; i < hist.size(); i++) s += int'(hist[i]);
    return s;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[u%0d] edge %0d: got %0d, expected %0d", name, k, edge_cnt, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [9:0] c, input logic f);
    exp_t e;
    while (qsize(k) > 0) begin
      e = qfront(k);
      if (e.stamp >= edge_cnt) break;
      qpop(k);
      tests++;
      fails++;
      $display("FAIL missed_strobe[u%0d]: expected strobe at edge %0d value %0d, cntr_valid stayed low",
               k, e.stamp, e.val);
    end
    if (v !== 1'b0) begin
      e.stamp = -1;
      if (qsize(k) > 0) e = qfront(k);
      if (e.stamp == edge_cnt) begin
        qpop(k);
        check("strobe_value", k, 32'(c), 32'(e.val));
      end else begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe[u%0d] edge %0d: cntr_valid=%b cntr=%0d, no strobe expected",
                 k, edge_cnt, v, c);
      end
    end
    check("cntr_hold", k, 32'(c), 32'(held[k]));
    check("filled", k, 32'(f), 32'(hist.size() >= wins[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, cv0, cntr0, f0);
      mon(1, cv1, cntr1, f1);
      mon(2, cv2, cntr2, f2);
    end
  end

  // Present one cycle of inputs and advance the reference model at that edge.
  task automatic drive(input logic r, input logic v, input logic b);
    exp_t e;
    @(negedge clk);
    rst = r;
    pdm_valid = v;
    pdm_bit = b;
    @(posedge clk);
    if (r) begin
      hist.delete();
      for (int k = 0; k < NI; k++) held[k] = 0;
      chk_en = 1'b1;
    end else if (v) begin
      hist.push_back(b);
      for (int k = 0; k < NI; k++) begin
        if (hist.size() >= wins[k] && (hist.size() - wins[k]) % decs[k] == 0) begin
          e.stamp = edge_cnt + 1;
          e.val   = win_sum(wins[k]);
          held[k] = e.val;
          qpush(k, e);
        end
      end
    end
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    settle();
    check("reset_cntr", 0, 32'(cntr0), 32'd0);
    check("reset_valid", 0, 32'(cv0), 32'd0);
    check("reset_filled", 0, 32'(f0), 32'd0);

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, pat[i]);
    settle();
    check("win2_final", 2, 32'(cntr2), 32'd2);

    drive(1'b1, 1'b0, 1'b0);
    repeat (1100) drive(1'b0, 1'b1, 1'b1);
    settle();
    check("all_ones", 0, 32'(cntr0), 32'd1000);
    check("all_ones_filled", 0, 32'(f0), 32'd1);
    check("all_ones_dec4", 1, 32'(cntr1), 32'd1000);

    repeat (1000) drive(1'b0, 1'b1, 1'b0);
    settle();
    check("drain_to_zero", 0, 32'(cntr0), 32'd0);

    for (int i = 0; i < 3000; i++) drive(1'b0, 1'b1, logic'(i % 2 == 0));
    settle();
    check("alternating", 0, 32'(cntr0), 32'd500);
    check("alternating_win2", 2, 32'(cntr2), 32'd1);

    repeat (1200) drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    repeat (999) drive(1'b0, 1'b1, 1'b0);
    settle();
    check("refill_pending", 0, 32'(f0), 32'd0);
    check("refill_cntr", 0, 32'(cntr0), 32'd0);
    drive(1'b0, 1'b1, 1'b0);
    settle();
    check("refill_done", 0, 32'(f0), 32'd1);
    check("refill_zero", 0, 32'(cntr0), 32'd0);

    for (int i = 0; i < 8000; i++) begin
      drive(logic'($urandom_range(0, 2999) == 0), logic'($urandom_range(0, 9) < 6),
            logic'($urandom_range(0, 1)));
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) check("queue_drained", k, 32'(qsize(k)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
